uart_apb_master: RTL
====================

Name: uart_apb_master

Overview:
APB initiator that issues single read/write transfers into the UART register block (pSel/pEnable/pWrite/pAddr/pWdata out, pReadData in). A host-side command source, such as a test sequencer or a future UART-to-bus bridge, drives it through a valid/ready command port and collects results on a valid/ready response port. One transfer is outstanding at a time. Sits beside the UART top on the same pClk domain.

Parameters:
ADDR_W, 32, APB address width
DATA_W, 32, APB data width
TIMEOUT_CYC, 16, ACCESS-phase cycles without pReady before abort (used only with the optional feature; legal range 1..255)

Ports:
pClk  input  1  system clock; all logic on its rising edge
pReset  input  1  asynchronous, active-low reset
cmd_valid  input  1  command present
cmd_ready  output  1  block can accept a command
cmd_write  input  1  1 = write, 0 = read
cmd_addr  input  ADDR_W  transfer address
cmd_wdata  input  DATA_W  write data (ignored for reads)
rsp_valid  output  1  response present
rsp_ready  input  1  response consumer ready
rsp_rdata  output  DATA_W  read data (0 for writes)
rsp_error  output  1  transfer aborted by timeout
pSel  output  1  APB select
pEnable  output  1  APB enable
pWrite  output  1  APB direction
pAddr  output  ADDR_W  APB address
pWdata  output  DATA_W  APB write data
pReadData  input  DATA_W  APB read data
pReady  input  1  APB ready; tie to 1 for the current UART register block

Behaviour:
- Reset (pReset=0, asynchronous): state=IDLE. pSel, pEnable, pWrite, rsp_valid and rsp_error are 0. pAddr, pWdata and rsp_rdata are 0. cmd_ready=0 while reset is asserted and 1 in IDLE after reset.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE: cmd_ready=1. If cmd_valid=1 at a clock edge, latch cmd_write/addr/wdata into pWrite/pAddr/pWdata and go to SETUP.
- SETUP (exactly 1 cycle): pSel=1, pEnable=0, cmd_ready=0. Next state is ACCESS.
- ACCESS: pSel=1, pEnable=1. pAddr, pWrite and pWdata are held stable.
  - At an edge with pReady=1: go to RESP, drop pSel/pEnable, load rsp_rdata with pReadData on reads or 0 on writes, rsp_error=0.
  - Otherwise stay in ACCESS.
- RESP: rsp_valid=1 and rsp_rdata/rsp_error are held until an edge with rsp_ready=1. That edge clears rsp_valid and returns to IDLE.
- No bypass: a new command is never accepted in the same cycle a response is consumed.
- Latency with pReady=1 and rsp_ready=1:
  - command accepted at edge 0
  - SETUP in cycle 1, ACCESS in cycle 2
  - rsp_valid high in cycle 3
  - next command acceptable in cycle 4
  - throughput is one transfer per 4 cycles.
- pSel and pEnable are never 1 together outside ACCESS. pEnable is never 1 without pSel.
- cmd_* inputs are ignored outside IDLE. Input changes mid-transfer do not disturb the APB outputs.
- Reset asserted mid-transfer: APB outputs drop immediately (asynchronous). No response is generated for the aborted command.
- pWdata keeps its last value after a transfer; it is not cleared.

Optional Feature:
APB_TIMEOUT_EN
- Defined:
  - An 8-bit counter clears on entry to ACCESS and increments each ACCESS cycle with pReady=0.
  - When the count reaches TIMEOUT_CYC with pReady still 0: go to RESP with rsp_error=1 and rsp_rdata=0, and drop pSel/pEnable.
  - pReady=1 in the same cycle the limit is hit wins: normal completion, rsp_error=0.
- Not defined: the counter is absent, ACCESS waits indefinitely, and rsp_error is tied to 0.

Test Plan:
- Write with pReady=1: cmd write addr=0x0000_0004, wdata=0x0000_00A5 -> SETUP cycle with pSel=1/pEnable=0, then ACCESS with pSel=1/pEnable=1/pWrite=1/pAddr=0x4/pWdata=0xA5 for one cycle, then rsp_valid=1, rsp_rdata=0, rsp_error=0 in cycle 3.
- Read: cmd read addr=0x0000_0008 with slave pReadData=0x0000_003C -> pWrite=0 during the transfer, rsp_rdata=0x3C, rsp_error=0.
- Wait states: pReady held 0 for 3 ACCESS cycles, then 1 -> pSel/pEnable/pAddr stable for 4 ACCESS cycles, response one cycle after pReady.
- Response backpressure: rsp_ready=0 for 5 cycles -> rsp_valid and rsp_rdata held; cmd_ready stays 0 until the cycle after the rsp_ready=1 handshake.
- Reset mid-ACCESS: pReset=0 asserted asynchronously -> pSel=0, pEnable=0, rsp_valid=0 immediately; after release cmd_ready=1 and no stale response appears.
- APB_TIMEOUT_EN with TIMEOUT_CYC=4 and pReady=0 forever -> rsp_error=1, rsp_rdata=0 after 4 ACCESS cycles; second run with pReady=1 on the 4th cycle -> rsp_error=0.

Source files
------------

// File: rtl/uart_apb_master.sv
// APB initiator: one transfer at a time, commands and responses on valid/ready ports.
// Optional macro APB_TIMEOUT_EN aborts an ACCESS phase after TIMEOUT_CYC cycles without pReady.
module uart_apb_master #(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic              pClk,
    input  logic              pReset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_error,
    output logic              pSel,
    output logic              pEnable,
    output logic              pWrite,
    output logic [ADDR_W-1:0] pAddr,
    output logic [DATA_W-1:0] pWdata,
    input  logic [DATA_W-1:0] pReadData,
    input  logic              pReady
);

    if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 255) begin : g_bad_timeout
        $error("TIMEOUT_CYC must be in 1..255");
    end

    typedef enum logic [1:0] {
        StIdle,
        StSetup,
        StAccess,
        StResp
    } state_e;

    state_e              state_q, state_d;
    logic                pwrite_q, pwrite_d;
    logic [ADDR_W-1:0]   paddr_q, paddr_d;
    logic [DATA_W-1:0]   pwdata_q, pwdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                access_abort;

`ifdef APB_TIMEOUT_EN
    localparam logic [7:0] TimeoutLast = 8'(TIMEOUT_CYC - 1);

    logic [7:0] cnt_q, cnt_d;
    logic       error_q, error_d;

    // The abort fires in the ACCESS cycle whose wait makes the count reach TIMEOUT_CYC.
    always_comb begin
        cnt_d        = cnt_q;
        error_d      = error_q;
        access_abort = 1'b0;
        if (state_q == StSetup) begin
            cnt_d = '0;
        end else if (state_q == StAccess) begin
            if (pReady) begin
                error_d = 1'b0;
            end else begin
                cnt_d = cnt_q + 8'd1;
                if (cnt_q == TimeoutLast) begin
                    access_abort = 1'b1;
                    error_d      = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge pClk or negedge pReset) begin
        if (!pReset) begin
            cnt_q   <= '0;
            error_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            error_q <= error_d;
        end
    end

    assign rsp_error = error_q;
`else
    assign access_abort = 1'b0;
    assign rsp_error    = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        pwrite_d = pwrite_q;
        paddr_d  = paddr_q;
        pwdata_d = pwdata_q;
        rdata_d  = rdata_q;
        case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    pwrite_d = cmd_write;
                    paddr_d  = cmd_addr;
                    pwdata_d = cmd_wdata;
                    state_d  = StSetup;
                end
            end
            StSetup: begin
                state_d = StAccess;
            end
            StAccess: begin
                if (pReady) begin
                    rdata_d = pwrite_q ? '0 : pReadData;
                    state_d = StResp;
                end else if (access_abort) begin
                    rdata_d = '0;
                    state_d = StResp;
                end
            end
            StResp: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge pClk or negedge pReset) begin
        if (!pReset) begin
            state_q  <= StIdle;
            pwrite_q <= 1'b0;
            paddr_q  <= '0;
            pwdata_q <= '0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            pwrite_q <= pwrite_d;
            paddr_q  <= paddr_d;
            pwdata_q <= pwdata_d;
            rdata_q  <= rdata_d;
        end
    end

    // Gating with pReset keeps cmd_ready low while reset is held, even though state is IDLE.
    assign cmd_ready = (state_q == StIdle) && pReset;
    assign rsp_valid = (state_q == StResp);
    assign rsp_rdata = rdata_q;
    assign pSel      = (state_q == StSetup) || (state_q == StAccess);
    assign pEnable   = (state_q == StAccess);
    assign pWrite    = pwrite_q;
    assign pAddr     = paddr_q;
    assign pWdata    = pwdata_q;

endmodule
